msg_receive_driver: RTL and testbench
=====================================

// Module: msg_receive_driver
// PURPOSE
// Receive end of the 128-bit message flow link. Parses the header beat, strips and
// re-packs body bytes into 128-bit payload words for a downstream FIFO, verifies the
// frame length and the 8-bit additive checksum, and reports per-frame status.
// Sits between the link deserializer and the application message FIFO.
// PARAMETERS
// HEADER_MAGIC    32'hEB90_EB90  required value of header bits [127:96]
// MAX_FIELD_LEN   16'd4096       largest accepted data-field length, in bytes
// TIMEOUT_CYCLES  1024           idle cycles allowed mid-frame before abort
// PORTS
// sys_clk_i          in   1    single clock
// rst_n_i            in   1    asynchronous reset, active low
// flow_valid_i       in   1    beat valid; no backpressure
// flow_data_i        in   128  beat data, byte 0 = bits[127:120]
// wr_en_o            out  1    payload word write strobe
// wr_data_o          out  128  payload word, first byte in [127:120], unused bytes 0
// wr_keep_o          out  5    valid byte count in word, 1..16
// wr_last_o          out  1    last payload word of frame
// full_i             in   1    downstream FIFO full
// rx_frame_type_o    out  4    latched header fields, updated on header accept
// rx_frame_cnt_o     out  16
// rx_src_id_o/rx_des_id_o/rx_data_type_o/rx_data_channel_o  out  8 each
// rx_field_len_o     out  16   data-field length L
// frame_done_o       out  1    one-cycle pulse, frame ended (good or aborted)
// frame_ok_o         out  1    valid with frame_done_o; 1 = no error
// err_o              out  4    sticky per frame {timeout,overflow,checksum,header}
// BEHAVIOUR
// - Reset: all outputs 0, state S_IDLE, counters and checksum cleared.
// - Header [95:80]=FL, [79:68]=0, [67:64] type, [63:48] cnt, [47:40] src, [39:32] des,
//   [31:24] dtype, [23:16] chan, [15:0] L. Accepted only if magic matches, [79:68]==0,
//   FL==(L+16)>>6 (17-bit add) and L<=MAX_FIELD_LEN.
// - Bad header in S_IDLE: frame_done_o=1, frame_ok_o=0, err_o=4'b0001 next cycle;
//   stay S_IDLE (resync on next valid magic).
// - Frame = T=(FL+1)*4 beats (19-bit), beat 0 header; beats 1..ceil(L/16) body;
//   remaining beats padding; byte 15 ([7:0]) of beat T-1 is checksum C.
// - C = 8-bit wrap sum of all 16 header bytes + L data bytes; bytes past L are
//   masked out of the sum.
// - States: S_IDLE -> S_BODY (L>0) or S_PAD (L==0) on good header; S_BODY -> S_PAD
//   after last body beat; S_PAD -> S_IDLE on beat T-1; S_DROP after overflow,
//   -> S_IDLE on beat T-1. Timeout from any non-idle state -> S_IDLE.
// - Body beat k: wr_en_o 1 cycle after the beat, wr_keep_o=min(16,L-16k),
//   wr_last_o on k=ceil(L/16)-1. Masked bytes driven 0.
// - Overflow: full_i high on a write cycle -> word dropped, err_o[2] set,
//   no further writes this frame, go S_DROP, beats still counted.
// - frame_done_o one cycle after beat T-1; checksum mismatch sets err_o[1].
// - Timeout: TIMEOUT_CYCLES consecutive cycles without flow_valid_i outside S_IDLE ->
//   err_o[3], frame_done_o pulse, S_IDLE; wr_last_o never issued for that frame.
// - Back-to-back: header on cycle after beat T-1 is accepted; done pulse of prior
//   frame still issued; err_o cleared at each header accept.
// - rst_n_i low mid-frame: immediate abort, no done pulse, outputs to reset values.
// TESTING
// - L=0, good C: 4 beats -> no wr_en_o, frame_done_o=1, frame_ok_o=1, err_o=0.
// - L=20 (FL=0): 4 beats -> 2 writes, keep 16 then 4 with wr_last_o, frame_ok_o=1.
// - L=48 (FL=1): 8 beats -> 3 writes keep 16, checksum read from beat 7 byte 15.
// - L=20, C corrupted by +1 -> frame_ok_o=0, err_o=4'b0010, both words still written.
// - L=48, full_i high during 2nd write -> 1 word written, err_o=4'b0100, done at beat 7.
// - Bad magic 32'h0 -> err_o=4'b0001 pulse; L=20 frame stalled after beat 1 for 1024
//   cycles -> err_o=4'b1000, S_IDLE; next good frame passes.

Source files
------------

// File: rtl/msg_receive_driver.sv
// ----------------------------------------------------------------------------
// msg_receive_driver
//   Receive end of the 128-bit message flow link. Validates the header beat,
//   strips body bytes into 128-bit payload words for the downstream message
//   FIFO, checks frame length and the 8-bit additive checksum, and reports a
//   one-cycle per-frame status pulse.
//
// Ports
//   sys_clk_i, rst_n_i           clock, async active-low reset
//   flow_valid_i, flow_data_i    incoming beats (no backpressure), byte 0 in [127:120]
//   wr_en_o, wr_data_o,          payload word stream to the FIFO; wr_keep_o is the
//   wr_keep_o, wr_last_o         valid byte count, wr_last_o marks the final word
//   full_i                       FIFO full; a write attempted while full is lost
//   rx_*_o                       header fields latched on header accept
//   frame_done_o, frame_ok_o     end-of-frame pulse and its pass/fail qualifier
//   err_o                        per-frame sticky {timeout,overflow,checksum,header}
// ----------------------------------------------------------------------------
module msg_receive_driver #(
    parameter logic [31:0] HEADER_MAGIC   = 32'hEB90_EB90,
    parameter logic [15:0] MAX_FIELD_LEN  = 16'd4096,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic         sys_clk_i,
    input  logic         rst_n_i,
    input  logic         flow_valid_i,
    input  logic [127:0] flow_data_i,
    output logic         wr_en_o,
    output logic [127:0] wr_data_o,
    output logic [4:0]   wr_keep_o,
    output logic         wr_last_o,
    input  logic         full_i,
    output logic [3:0]   rx_frame_type_o,
    output logic [15:0]  rx_frame_cnt_o,
    output logic [7:0]   rx_src_id_o,
    output logic [7:0]   rx_des_id_o,
    output logic [7:0]   rx_data_type_o,
    output logic [7:0]   rx_data_channel_o,
    output logic [15:0]  rx_field_len_o,
    output logic         frame_done_o,
    output logic         frame_ok_o,
    output logic [3:0]   err_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BODY = 2'd1;
    localparam logic [1:0] S_PAD  = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    // ------------------------------------------------------------------
    // Header decode (only meaningful when the beat is a header candidate)
    // ------------------------------------------------------------------
    logic [31:0] h_magic;
    logic [15:0] h_fl;
    logic [11:0] h_rsv;
    logic [3:0]  h_type;
    logic [15:0] h_cnt;
    logic [7:0]  h_src, h_des, h_dtype, h_chan;
    logic [15:0] h_len;
    logic [16:0] fl_calc;
    logic        hdr_ok;

    assign h_magic = flow_data_i[127:96];
    assign h_fl    = flow_data_i[95:80];
    assign h_rsv   = flow_data_i[79:68];
    assign h_type  = flow_data_i[67:64];
    assign h_cnt   = flow_data_i[63:48];
    assign h_src   = flow_data_i[47:40];
    assign h_des   = flow_data_i[39:32];
    assign h_dtype = flow_data_i[31:24];
    assign h_chan  = flow_data_i[23:16];
    assign h_len   = flow_data_i[15:0];

    // 17-bit add so L near 16'hFFFF cannot wrap into a small FL
    assign fl_calc = (17'(h_len) + 17'd16) >> 6;
    assign hdr_ok  = (h_magic == HEADER_MAGIC) && (h_rsv == 12'd0) &&
                     ({1'b0, h_fl} == fl_calc) && (h_len <= MAX_FIELD_LEN);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]   state_q, state_d;
    logic [18:0]  beat_q, beat_d;      // index of the next expected beat
    logic [18:0]  last_q, last_d;      // index of the checksum beat, T-1
    logic [16:0]  rem_q, rem_d;        // data bytes still to come
    logic [7:0]   sum_q, sum_d;
    logic [3:0]   err_q, err_d;
    logic         done_q, done_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic         wr_vld_q, wr_vld_d;
    logic         wr_last_q, wr_last_d;
    logic [127:0] wr_data_q, wr_data_d;
    logic [4:0]   wr_keep_q, wr_keep_d;

    logic [3:0]   rx_type_q;
    logic [15:0]  rx_cnt_q, rx_len_q;
    logic [7:0]   rx_src_q, rx_des_q, rx_dtype_q, rx_chan_q;

    // ------------------------------------------------------------------
    // Byte masking and checksum contributions of the current beat
    // ------------------------------------------------------------------
    logic [4:0]   keep_w;
    logic [127:0] mdata;
    logic [7:0]   dsum;
    logic [7:0]   hsum;

    // rem_q == 0 (padding) yields keep 0, so padding never enters the sum
    assign keep_w = (rem_q >= 17'd16) ? 5'd16 : rem_q[4:0];

    always_comb begin
        mdata = '0;
        dsum  = '0;
        hsum  = '0;
        for (int i = 0; i < 16; i++) begin
            hsum = hsum + flow_data_i[127-8*i -: 8];
            if (5'(i) < keep_w) begin
                mdata[127-8*i -: 8] = flow_data_i[127-8*i -: 8];
                dsum = dsum + flow_data_i[127-8*i -: 8];
            end
        end
    end

    // A word presented while the FIFO is full is lost; the frame stops writing.
    logic ovf_now;
    logic hdr_acc;

    assign ovf_now = wr_vld_q & full_i;
    assign hdr_acc = (state_q == S_IDLE) && flow_valid_i && hdr_ok;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        last_d    = last_q;
        rem_d     = rem_q;
        sum_d     = sum_q;
        err_d     = err_q | {1'b0, ovf_now, 2'b00};
        done_d    = 1'b0;
        to_cnt_d  = to_cnt_q;
        wr_vld_d  = 1'b0;
        wr_last_d = 1'b0;
        wr_data_d = wr_data_q;
        wr_keep_d = wr_keep_q;

        if (state_q == S_IDLE) begin
            to_cnt_d = '0;
            if (flow_valid_i) begin
                if (hdr_ok) begin
                    err_d   = 4'b0000;
                    sum_d   = hsum;
                    rem_d   = 17'(h_len);
                    beat_d  = 19'd1;
                    last_d  = ((19'(h_fl) + 19'd1) << 2) - 19'd1;
                    state_d = (h_len == 16'd0) ? S_PAD : S_BODY;
                end else begin
                    // stay idle and keep hunting for the next valid magic
                    err_d  = 4'b0001;
                    done_d = 1'b1;
                end
            end
        end else if (flow_valid_i) begin
            to_cnt_d = '0;
            beat_d   = beat_q + 19'd1;
            sum_d    = sum_q + dsum;
            rem_d    = rem_q - 17'(keep_w);
            if (state_q == S_BODY) begin
                if (!ovf_now) begin
                    wr_vld_d  = 1'b1;
                    wr_data_d = mdata;
                    wr_keep_d = keep_w;
                    wr_last_d = (rem_q <= 17'd16);
                end
                if (rem_q <= 17'd16)
                    state_d = S_PAD;
            end
            if (ovf_now)
                state_d = S_DROP;
            // The checksum beat can also be the final body beat when L%16 != 0;
            // byte 15 then lies past L and is already masked out of dsum.
            if (beat_q == last_q) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if ((sum_q + dsum) != flow_data_i[7:0])
                    err_d[1] = 1'b1;
            end
        end else begin
            if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d  = S_IDLE;
                done_d   = 1'b1;
                err_d[3] = 1'b1;
                to_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
            if (ovf_now && state_d != S_IDLE)
                state_d = S_DROP;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            last_q    <= '0;
            rem_q     <= '0;
            sum_q     <= '0;
            err_q     <= '0;
            done_q    <= 1'b0;
            to_cnt_q  <= '0;
            wr_vld_q  <= 1'b0;
            wr_last_q <= 1'b0;
            wr_data_q <= '0;
            wr_keep_q <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            last_q    <= last_d;
            rem_q     <= rem_d;
            sum_q     <= sum_d;
            err_q     <= err_d;
            done_q    <= done_d;
            to_cnt_q  <= to_cnt_d;
            wr_vld_q  <= wr_vld_d;
            wr_last_q <= wr_last_d;
            wr_data_q <= wr_data_d;
            wr_keep_q <= wr_keep_d;
        end
    end

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_type_q  <= '0;
            rx_cnt_q   <= '0;
            rx_src_q   <= '0;
            rx_des_q   <= '0;
            rx_dtype_q <= '0;
            rx_chan_q  <= '0;
            rx_len_q   <= '0;
        end else if (hdr_acc) begin
            rx_type_q  <= h_type;
            rx_cnt_q   <= h_cnt;
            rx_src_q   <= h_src;
            rx_des_q   <= h_des;
            rx_dtype_q <= h_dtype;
            rx_chan_q  <= h_chan;
            rx_len_q   <= h_len;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wr_en_o   = wr_vld_q & ~full_i;
    assign wr_last_o = wr_last_q & wr_vld_q & ~full_i;
    assign wr_data_o = wr_data_q;
    assign wr_keep_o = wr_keep_q;

    // An overflow on the final word lands in the same cycle as the done
    // pulse, so fold it into the status combinationally.
    assign err_o        = err_q | {1'b0, ovf_now, 2'b00};
    assign frame_done_o = done_q;
    assign frame_ok_o   = done_q & ~(|err_o);

    assign rx_frame_type_o   = rx_type_q;
    assign rx_frame_cnt_o    = rx_cnt_q;
    assign rx_src_id_o       = rx_src_q;
    assign rx_des_id_o       = rx_des_q;
    assign rx_data_type_o    = rx_dtype_q;
    assign rx_data_channel_o = rx_chan_q;
    assign rx_field_len_o    = rx_len_q;

endmodule

// File: tb/tb_msg_receive_driver.sv
module tb_msg_receive_driver;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid;
    logic [127:0] data;
    logic         full;
    logic         wr_en_o, wr_last_o;
    logic [127:0] wr_data_o;
    logic [4:0]   wr_keep_o;
    logic [3:0]   rx_frame_type_o;
    logic [15:0]  rx_frame_cnt_o, rx_field_len_o;
    logic [7:0]   rx_src_id_o, rx_des_id_o, rx_data_type_o, rx_data_channel_o;
    logic         frame_done_o, frame_ok_o;
    logic [3:0]   err_o;

    always #5 clk = ~clk;

    msg_receive_driver dut (
        .sys_clk_i(clk), .rst_n_i(rst_n),
        .flow_valid_i(valid), .flow_data_i(data),
        .wr_en_o(wr_en_o), .wr_data_o(wr_data_o), .wr_keep_o(wr_keep_o),
        .wr_last_o(wr_last_o), .full_i(full),
        .rx_frame_type_o(rx_frame_type_o), .rx_frame_cnt_o(rx_frame_cnt_o),
        .rx_src_id_o(rx_src_id_o), .rx_des_id_o(rx_des_id_o),
        .rx_data_type_o(rx_data_type_o), .rx_data_channel_o(rx_data_channel_o),
        .rx_field_len_o(rx_field_len_o),
        .frame_done_o(frame_done_o), .frame_ok_o(frame_ok_o), .err_o(err_o)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    // captured write and status events
    logic [127:0] wq_data[$];
    logic [4:0]   wq_keep[$];
    logic         wq_last[$];
    int           dq_cyc[$];
    logic         dq_ok[$];
    logic [3:0]   dq_err[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en_o) begin
                wq_data.push_back(wr_data_o);
                wq_keep.push_back(wr_keep_o);
                wq_last.push_back(wr_last_o);
            end
            if (frame_done_o) begin
                dq_cyc.push_back(cyc);
                dq_ok.push_back(frame_ok_o);
                dq_err.push_back(err_o);
            end
        end
    end

    task automatic clear_q();
        wq_data.delete(); wq_keep.delete(); wq_last.delete();
        dq_cyc.delete(); dq_ok.delete(); dq_err.delete();
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] dbyte(input int len, input int j);
        logic [31:0] t;
        t = j * 37 + len * 5 + 1;
        return t[7:0];
    endfunction

    function automatic logic [127:0] exp_word(input int len, input int k);
        logic [127:0] w;
        w = '0;
        for (int i = 0; i < 16; i++)
            if (16 * k + i < len) w[127-8*i -: 8] = dbyte(len, 16 * k + i);
        return w;
    endfunction

    logic [127:0] beats [0:300];
    int nbeats;

    task automatic build(input int len, input int corrupt, input logic [31:0] magic);
        int fl, b, p;
        logic [7:0] cs;
        logic [127:0] h;
        logic [15:0] fl16, len16, cnt16;
        fl = (len + 16) >> 6;
        nbeats = (fl + 1) * 4;
        fl16 = 16'(fl); len16 = 16'(len); cnt16 = 16'(16'h1200 + len);
        h = {magic, fl16, 12'h000, 4'h5, cnt16, 8'hA1, 8'hB2, 8'hC3, 8'hD4, len16};
        for (int i = 0; i < nbeats; i++) beats[i] = '0;
        beats[0] = h;
        cs = '0;
        for (int i = 0; i < 16; i++) cs = cs + h[127-8*i -: 8];
        for (int j = 0; j < len; j++) begin
            b = 1 + j / 16;
            p = j % 16;
            beats[b][127-8*p -: 8] = dbyte(len, j);
            cs = cs + dbyte(len, j);
        end
        beats[nbeats-1][7:0] = cs + 8'(corrupt);
    endtask

    // full_wr = n holds full_i during the cycle the n-th word is presented
    task automatic send_beats(input int n, input int full_wr);
        for (int b = 0; b < n; b++) begin
            @(posedge clk); #1;
            valid = 1'b1;
            data  = beats[b];
            full  = (full_wr > 0) && (b == full_wr + 1);
            last_cyc = cyc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            valid = 1'b0; data = '0; full = 1'b0;
        end
    endtask

    typedef struct {
        int         len;
        int         corrupt;
        int         full_wr;
        int         exp_wr;
        bit         exp_ok;
        logic [3:0] exp_err;
    } vec_t;

    localparam int NV = 7;
    vec_t vec [NV];

    initial begin
        vec[0] = '{len:0,   corrupt:0, full_wr:0, exp_wr:0, exp_ok:1'b1, exp_err:4'b0000};
        vec[1] = '{len:20,  corrupt:0, full_wr:0, exp_wr:2, exp_ok:1'b1, exp_err:4'b0000};
        vec[2] = '{len:48,  corrupt:0, full_wr:0, exp_wr:3, exp_ok:1'b1, exp_err:4'b0000};
        vec[3] = '{len:20,  corrupt:1, full_wr:0, exp_wr:2, exp_ok:1'b0, exp_err:4'b0010};
        vec[4] = '{len:48,  corrupt:0, full_wr:2, exp_wr:1, exp_ok:1'b0, exp_err:4'b0100};
        vec[5] = '{len:47,  corrupt:0, full_wr:0, exp_wr:3, exp_ok:1'b1, exp_err:4'b0000};
        vec[6] = '{len:100, corrupt:0, full_wr:0, exp_wr:7, exp_ok:1'b1, exp_err:4'b0000};

        rst_n = 1'b0; valid = 1'b0; data = '0; full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst wr_en", wr_en_o, 0);
        chk("rst wr_data", wr_data_o, 0);
        chk("rst wr_keep", wr_keep_o, 0);
        chk("rst done", frame_done_o, 0);
        chk("rst ok", frame_ok_o, 0);
        chk("rst err", err_o, 0);
        chk("rst len", rx_field_len_o, 0);
        rst_n = 1'b1;
        idle(2);

        for (int v = 0; v < NV; v++) begin
            clear_q();
            build(vec[v].len, vec[v].corrupt, 32'hEB90_EB90);
            send_beats(nbeats, vec[v].full_wr);
            idle(4);
            chk($sformatf("v%0d nwr", v), wq_data.size(), vec[v].exp_wr);
            for (int i = 0; i < wq_data.size() && i < vec[v].exp_wr; i++) begin
                int k;
                k = vec[v].len - 16 * i;
                if (k > 16) k = 16;
                chk($sformatf("v%0d w%0d data", v, i), wq_data[i], exp_word(vec[v].len, i));
                chk($sformatf("v%0d w%0d keep", v, i), wq_keep[i], k);
                chk($sformatf("v%0d w%0d last", v, i), wq_last[i],
                    (vec[v].full_wr == 0) && (i == vec[v].exp_wr - 1));
            end
            chk($sformatf("v%0d ndone", v), dq_ok.size(), 1);
            if (dq_ok.size() > 0) begin
                chk($sformatf("v%0d ok", v), dq_ok[0], vec[v].exp_ok);
                chk($sformatf("v%0d err", v), dq_err[0], vec[v].exp_err);
                chk($sformatf("v%0d done cyc", v), dq_cyc[0], last_cyc + 1);
            end
            chk($sformatf("v%0d rx len", v), rx_field_len_o, vec[v].len);
            chk($sformatf("v%0d rx cnt", v), rx_frame_cnt_o, 16'h1200 + vec[v].len);
        end
        chk("rx src", rx_src_id_o, 8'hA1);
        chk("rx chan", rx_data_channel_o, 8'hD4);
        chk("rx type", rx_frame_type_o, 4'h5);

        // bad magic: single error pulse, block stays idle
        clear_q();
        build(20, 0, 32'h0);
        send_beats(1, 0);
        idle(3);
        chk("badhdr ndone", dq_ok.size(), 1);
        if (dq_ok.size() > 0) begin
            chk("badhdr err", dq_err[0], 4'b0001);
            chk("badhdr ok", dq_ok[0], 0);
        end
        chk("badhdr rx len", rx_field_len_o, 100);

        // stall after beat 1 until timeout
        clear_q();
        build(20, 0, 32'hEB90_EB90);
        send_beats(2, 0);
        valid = 1'b1;
        for (int i = 0; i < 1200 && dq_ok.size() == 0; i++) idle(1);
        chk("tmo ndone", dq_ok.size(), 1);
        if (dq_ok.size() > 0) begin
            chk("tmo err", dq_err[0], 4'b1000);
            chk("tmo ok", dq_ok[0], 0);
            chk("tmo latency", dq_cyc[0] - last_cyc, 1025);
        end
        chk("tmo nwr", wq_data.size(), 1);
        if (wq_last.size() > 0) chk("tmo no last", wq_last[0], 0);

        // next good frame after timeout
        clear_q();
        build(20, 0, 32'hEB90_EB90);
        send_beats(nbeats, 0);
        idle(4);
        chk("post tmo nwr", wq_data.size(), 2);
        chk("post tmo ndone", dq_ok.size(), 1);
        if (dq_ok.size() > 0) chk("post tmo ok", dq_ok[0], 1);

        // back-to-back frames: L=20 immediately followed by L=48
        clear_q();
        build(20, 0, 32'hEB90_EB90);
        send_beats(nbeats, 0);
        build(48, 0, 32'hEB90_EB90);
        send_beats(nbeats, 0);
        idle(4);
        chk("b2b nwr", wq_data.size(), 5);
        chk("b2b ndone", dq_ok.size(), 2);
        if (dq_ok.size() > 1) begin
            chk("b2b ok0", dq_ok[0], 1);
            chk("b2b ok1", dq_ok[1], 1);
            chk("b2b err1", dq_err[1], 0);
        end
        if (wq_data.size() > 4) chk("b2b w4 data", wq_data[4], exp_word(48, 2));

        // reset mid-frame
        clear_q();
        build(48, 0, 32'hEB90_EB90);
        send_beats(2, 0);
        @(posedge clk); #1;
        valid = 1'b0; data = '0;
        rst_n = 1'b0;
        #1;
        chk("midrst wr_en", wr_en_o, 0);
        chk("midrst len", rx_field_len_o, 0);
        chk("midrst err", err_o, 0);
        idle(2);
        rst_n = 1'b1;
        idle(3);
        chk("midrst ndone", dq_ok.size(), 0);
        clear_q();
        build(0, 0, 32'hEB90_EB90);
        send_beats(nbeats, 0);
        idle(4);
        chk("after rst ndone", dq_ok.size(), 1);
        if (dq_ok.size() > 0) chk("after rst ok", dq_ok[0], 1);
        chk("after rst nwr", wq_data.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
